array_access_ctrl: RTL and testbench

//  Shares one array memory block (trigger/write/addr/writevalue -> readvalue/done) among NREQ

---
 rtl/arrctl_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/array_access_ctrl.sv | 154 +++++++++++++++
 tb/tb_array_access_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arrctl_pkg.sv
// Shared types for the array access controller.
// State encoding and response status values.
package arrctl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  localparam logic RSP_OK  = 1'b0;
  localparam logic RSP_ERR = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set req bit at or after ptr, wrapping.
// Ports: req, ptr in; gnt (one-hot), idx (encoded), any out.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);

  localparam int IW = $clog2(NREQ);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/array_access_ctrl.sv
// Shares one array block among NREQ requesters: round-robin grant,
// bounds check, done timeout, one response per request.
// Ports: clk/rst; req/req_write/req_addr/req_wdata in; gnt out;
// rsp_valid/rsp_rdata/rsp_err out; arr_* to/from the array block.
module array_access_ctrl
  import arrctl_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int ARR_SIZE = 1024,
  parameter int ARR_LEN  = 1024,
  parameter int TIMEOUT  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NREQ-1:0]                  req,
  input  logic [NREQ-1:0]                  req_write,
  input  logic [NREQ*$clog2(ARR_SIZE)-1:0] req_addr,
  input  logic [NREQ*32-1:0]               req_wdata,
  output logic [NREQ-1:0]                  gnt,
  output logic [NREQ-1:0]                  rsp_valid,
  output logic [31:0]                      rsp_rdata,
  output logic                             rsp_err,
  output logic                             arr_trigger,
  output logic                             arr_write,
  output logic [$clog2(ARR_SIZE)-1:0]      arr_addr,
  output logic [31:0]                      arr_wdata,
  input  logic [31:0]                      arr_rdata,
  input  logic                             arr_done
);

  localparam int ADDR = $clog2(ARR_SIZE);
  localparam int IW   = $clog2(NREQ);
  localparam int CW   = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic            op_q, op_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic            oob;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req),
    .ptr (rr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign oob = 32'(addr_q) >= 32'(ARR_LEN);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rr_d        = rr_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    gnt         = '0;
    rsp_valid   = '0;
    rsp_rdata   = '0;
    rsp_err     = 1'b0;
    arr_trigger = 1'b0;
    arr_write   = 1'b0;
    arr_addr    = '0;
    arr_wdata   = '0;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          gnt     = arb_gnt;
          idx_d   = arb_idx;
          op_d    = req_write[arb_idx];
          addr_d  = req_addr[arb_idx*ADDR +: ADDR];
          wdata_d = req_wdata[arb_idx*32 +: 32];
          rdata_d = '0;
          err_d   = RSP_OK;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        arr_addr  = addr_q;
        arr_wdata = wdata_q;
        if (oob) begin
          // never touch the block for a bad index
          err_d   = RSP_ERR;
          state_d = RESP;
        end else begin
          arr_trigger = 1'b1;
          arr_write   = op_q;
          cnt_d       = '0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        arr_addr  = addr_q;
        arr_wdata = wdata_q;
        arr_write = op_q;
        if (arr_done) begin
          rdata_d = op_q ? 32'd0 : arr_rdata;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = RSP_ERR;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        rsp_valid[idx_q] = 1'b1;
        rsp_rdata        = rdata_q;
        rsp_err          = err_q;
        rr_d = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rr_q    <= '0;
      op_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_array_access_ctrl.sv
// Bench for array_access_ctrl with a behavioural array block
// and a transaction-level reference model.
module tb_array_access_ctrl;

  localparam int NREQ = 2;
  localparam int ASZ  = 1024;
  localparam int ALEN = 1000;
  localparam int TO   = 16;
  localparam int AW   = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req, req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*32-1:0] req_wdata;
  logic [NREQ-1:0]   gnt, rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              arr_trigger, arr_write;
  logic [AW-1:0]     arr_addr;
  logic [31:0]       arr_wdata, arr_rdata;
  logic              arr_done;

  array_access_ctrl #(
    .NREQ(NREQ), .ARR_SIZE(ASZ), .ARR_LEN(ALEN), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .arr_trigger(arr_trigger), .arr_write(arr_write),
    .arr_addr(arr_addr), .arr_wdata(arr_wdata),
    .arr_rdata(arr_rdata), .arr_done(arr_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // array block model and reference state
  logic [31:0] amem [ASZ];
  logic [31:0] rmem [ASZ];
  logic [AW-1:0] aaddr;
  int apend = 0;
  int lat_force = 0;
  bit stub = 0;
  int trig_cnt = 0;

  // outstanding transaction seen by the monitor
  bit          out_v = 0;
  int          out_id, out_age;
  bit          out_w, out_trig, out_err;
  logic [AW-1:0] out_a;
  logic [31:0] out_wd, out_rd;
  int          last = NREQ - 1;
  logic [31:0] last_rd [NREQ];
  logic        last_err [NREQ];
  int          gq [$];

  always @(negedge clk) begin : mon
    logic pd;
    int w;
    pd = arr_done;
    if (rst) begin
      out_v = 0;
      last  = NREQ - 1;
    end else begin
      if (out_v) out_age++;
      if (!out_v && rsp_valid == 0)
        check("idle_bus", {22'b0, arr_addr, arr_wdata}, 64'd0);
      if (rsp_valid != 0) begin
        check("rsp_owner", rsp_valid, out_v ? 2'(1 << out_id) : 2'b0);
        if (out_v) begin
          check("rsp_rdata", rsp_rdata, out_rd);
          check("rsp_err", rsp_err, out_err);
          if (out_trig && !stub) check("rsp_after_done", pd, 1);
          if (out_a >= ALEN) check("oob_lat", out_age, 2);
          else if (stub) check("to_lat", out_age, TO + 2);
          last_rd[out_id]  = rsp_rdata;
          last_err[out_id] = rsp_err;
          last  = out_id;
          out_v = 0;
        end
      end else if (out_v && out_trig && pd && !stub) begin
        check("rsp_missing", rsp_valid, 2'(1 << out_id));
      end
      if (out_v && out_age > 60) begin
        check("rsp_overdue", out_age, 0);
        out_v = 0;
      end
      if (arr_trigger) begin
        check("trig_pending", out_v, 1);
        if (out_v) begin
          check("trig_lat", out_age, 1);
          check("trig_addr", arr_addr, out_a);
          check("trig_write", arr_write, out_w);
          check("trig_inrange", out_a >= ALEN, 0);
          if (out_w) check("trig_wdata", arr_wdata, out_wd);
          out_trig = 1;
        end
      end
      if (arr_write)
        check("write_ok", out_v && out_w && out_a < ALEN, 1);
      if (gnt != 0) begin
        w = -1;
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && req[(last + 1 + k) % NREQ]) w = (last + 1 + k) % NREQ;
        check("gnt_busy", out_v, 0);
        check("gnt_winner", gnt, w < 0 ? 2'b0 : 2'(1 << w));
        if (w >= 0) begin
          out_v    = 1;
          out_id   = w;
          out_age  = 0;
          out_trig = 0;
          out_w    = req_write[w];
          out_a    = req_addr[w*AW +: AW];
          out_wd   = req_wdata[w*32 +: 32];
          out_rd   = 32'd0;
          out_err  = 0;
          if (out_a >= ALEN || stub) out_err = 1;
          else if (out_w) rmem[out_a] = out_wd;
          else out_rd = rmem[out_a];
          gq.push_back(w);
        end
      end
    end
    // array block: write on trigger, done after a variable delay
    arr_done  = 1'b0;
    arr_rdata = $urandom;
    if (apend > 0) begin
      apend--;
      if (apend == 0 && !stub) begin
        arr_done  = 1'b1;
        arr_rdata = amem[aaddr];
      end
    end
    if (arr_trigger) begin
      trig_cnt++;
      aaddr = arr_addr;
      if (arr_write) amem[arr_addr] = arr_wdata;
      apend = (lat_force > 0) ? lat_force : $urandom_range(1, 4);
    end
  end

  task automatic issue(int i, bit w, logic [AW-1:0] a,
                       logic [31:0] d, bit hold);
    bit got;
    @(posedge clk); #1;
    req[i]              = 1'b1;
    req_write[i]        = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*32 +: 32] = d;
    got = 0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      got = gnt[i];
    end
    check("gnt_wait", got, 1);
    if (!hold || !got) begin
      @(posedge clk); #1;
      req[i]                = 1'b0;
      req_write[i]          = 1'($urandom);
      req_addr[i*AW +: AW]  = AW'($urandom);
      req_wdata[i*32 +: 32] = $urandom;
    end
  endtask

  task automatic poke(int i, bit w, logic [AW-1:0] a, logic [31:0] d);
    @(posedge clk); #1;
    req[i]                = 1'b1;
    req_write[i]          = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*32 +: 32] = d;
    @(posedge clk); #1;
    req[i] = 1'b0;
  endtask

  task automatic wait_rsp(int i);
    bit got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      got = rsp_valid[i];
    end
    check("rsp_wait", got, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 200 && out_v; c++) @(posedge clk);
    check("idle_wait", out_v, 0);
    @(posedge clk); #1;
  endtask

  task automatic rand_req(int i, int n);
    bit w;
    logic [AW-1:0] a;
    logic [31:0] d;
    for (int k = 0; k < n; k++) begin
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = AW'(995 + $urandom_range(0, 28));
      else a = AW'($urandom_range(0, 15));
      d = $urandom;
      if ($urandom_range(0, 5) == 0) poke(i, w, a, d);
      else issue(i, w, a, d, (k < n - 1) && ($urandom_range(0, 1) == 1));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    @(posedge clk); #1;
    req[i] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int trig0;
    rst = 1'b1;
    req = '0;
    req_write = '0;
    req_addr = '0;
    req_wdata = '0;
    arr_done = 1'b0;
    arr_rdata = '0;
    for (int k = 0; k < ASZ; k++) begin
      amem[k] = 32'd0;
      rmem[k] = 32'd0;
    end
    amem[1000] = 32'h5A5A5A5A;
    rmem[1000] = 32'h5A5A5A5A;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ctl", {gnt, rsp_valid, rsp_err, arr_trigger, arr_write, arr_addr}, 0);
    check("rst_data", {rsp_rdata, arr_wdata}, 0);

    // preload addr 1 and 2, leaving requester 1 as last served
    issue(0, 1'b1, 10'd1, 32'h11111111, 1'b0);
    wait_rsp(0);
    issue(1, 1'b1, 10'd2, 32'h22222222, 1'b0);
    wait_rsp(1);

    // simultaneous loads
    gq.delete();
    fork
      issue(0, 1'b0, 10'd1, 32'h0, 1'b0);
      issue(1, 1'b0, 10'd2, 32'h0, 1'b0);
    join
    wait_idle();
    check("t2_n", gq.size(), 2);
    if (gq.size() == 2) begin
      check("t2_first", gq[0], 0);
      check("t2_second", gq[1], 1);
    end
    check("t2_rd0", last_rd[0], 32'h11111111);
    check("t2_rd1", last_rd[1], 32'h22222222);

    // store then load
    issue(0, 1'b1, 10'd5, 32'hDEADBEEF, 1'b0);
    wait_rsp(0);
    check("t1_st_err", last_err[0], 0);
    check("t1_st_rd", last_rd[0], 0);
    issue(0, 1'b0, 10'd5, 32'h0, 1'b0);
    wait_rsp(0);
    check("t1_rdata", last_rd[0], 32'hDEADBEEF);
    check("t1_err", last_err[0], 0);

    // both held: rotation 1,0,1,0,... after requester 0 was last
    gq.delete();
    fork
      for (int k = 0; k < 3; k++) issue(0, 1'b0, AW'(k), 32'h0, k < 2);
      for (int k = 0; k < 3; k++) issue(1, 1'b0, AW'(k + 3), 32'h0, k < 2);
    join
    wait_idle();
    check("t3_n", gq.size(), 6);
    for (int k = 0; k < gq.size(); k++) check("t3_order", gq[k], (k + 1) % 2);

    // out-of-range store
    trig0 = trig_cnt;
    issue(1, 1'b1, 10'd1000, 32'hCAFEF00D, 1'b0);
    wait_rsp(1);
    check("t4_err", last_err[1], 1);
    check("t4_notrig", trig_cnt - trig0, 0);
    check("t4_mem", amem[1000], 32'h5A5A5A5A);

    // block never answers
    stub = 1;
    issue(0, 1'b0, 10'd7, 32'h0, 1'b0);
    wait_rsp(0);
    check("t5_err", last_err[0], 1);
    check("t5_rd", last_rd[0], 0);
    stub = 0;
    issue(0, 1'b0, 10'd5, 32'h0, 1'b0);
    wait_rsp(0);
    check("t5_after_rd", last_rd[0], 32'hDEADBEEF);
    check("t5_after_err", last_err[0], 0);

    // reset while a store waits for done
    lat_force = 10;
    issue(1, 1'b1, 10'd9, 32'h12345678, 1'b0);
    begin
      bit seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk);
        seen = arr_trigger;
      end
      check("t6_trig", seen, 1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_wr_next", arr_write, 0);
    check("t6_ctl", {gnt, rsp_valid, rsp_err, arr_trigger, arr_write, arr_addr}, 0);
    check("t6_data", {rsp_rdata, arr_wdata}, 0);
    repeat (12) begin
      @(negedge clk);
      check("t6_no_rsp", rsp_valid, 0);
    end
    lat_force = 0;
    @(posedge clk); #1;

    // random traffic against the reference model
    fork
      rand_req(0, 60);
      rand_req(1, 60);
    join
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
